// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, addr_w() address-width helper,
//           sat_shift() fixed-point rescale with saturation.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Address width for a memory of 'depth' words, never narrower than 1 bit.
  function automatic int addr_w(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

  // Arithmetic right shift by 'frac' (rounds toward -inf), then clamp to a
  // signed 'data_w'-bit range. Operates at a fixed wide width so a single
  // function serves every parameterisation; callers cast the result down.
  function automatic logic signed [63:0] sat_shift(input logic signed [127:0] acc,
                                                   input int frac,
                                                   input int data_w);
    logic signed [127:0] sh;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    sh = acc >>> frac;
    hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (data_w - 1));
    if (sh > hi) begin
      return 64'(hi);
    end
    if (sh < lo) begin
      return 64'(lo);
    end
    return 64'(sh);
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Operand/result bus between the sequencer and its three external RAMs.
// Latency: A/B read data is expected one cycle after the read strobe.
// Backpressure: none; RAMs must accept a read or write every cycle.
// Signals: start/busy/done control, A and B read ports, C write port.
// Modports: master = sequencer side, slave = environment (RAMs + controller).
interface matmul_sequencer_if
  import matmul_pkg::*;
#(
  parameter int M1     = 2,
  parameter int N1     = 2,
  parameter int N2     = 2,
  parameter int DATA_W = 16
) ();

  localparam int AW_A = addr_w(M1 * N1);
  localparam int AW_B = addr_w(N1 * N2);
  localparam int AW_R = addr_w(M1 * N2);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     a_rd_en;
  logic [AW_A-1:0]          a_addr;
  logic signed [DATA_W-1:0] a_data;
  logic                     b_rd_en;
  logic [AW_B-1:0]          b_addr;
  logic signed [DATA_W-1:0] b_data;
  logic                     r_we;
  logic [AW_R-1:0]          r_addr;
  logic signed [DATA_W-1:0] r_data;

  modport master (
    input  start, a_data, b_data,
    output busy, done, a_rd_en, a_addr, b_rd_en, b_addr, r_we, r_addr, r_data
  );

  modport slave (
    output start, a_data, b_data,
    input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr, r_we, r_addr, r_data
  );

endinterface

// File: rtl/fixed_mac.sv
// Signed multiply-accumulate with a load-on-first input (no clear cycle).
// Latency: o_acc reflects the operands one cycle after i_vld.
// Backpressure: none; every valid operand pair is consumed.
// Ports: clk, rst (sync, active-high), i_a/i_b operands, i_vld operand strobe,
//        i_first (load instead of add), o_acc registered accumulator.
module fixed_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic                     i_vld,
  input  logic                     i_first,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod     = i_a * i_b;
  assign w_prod_ext = ACC_W'(w_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_vld) begin
      r_acc <= i_first ? w_prod_ext : (r_acc + w_prod_ext);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/matmul_sequencer.sv
// Computes C = A x B one element at a time through a single shared MAC.
// Latency: N1+2 cycles per C element; done pulses after M1*N2*(N1+2) busy cycles.
// Backpressure: none; start is only honoured in IDLE, RAMs are never stalled.
// Ports: clk, rst (sync, active-high), bus (master side of matmul_sequencer_if):
//        start/busy/done control, A/B read strobes+addresses+data, C write port.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int M1     = 2,
  parameter int N1     = 2,
  parameter int N2     = 2,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic               clk,
  input  logic               rst,
  matmul_sequencer_if.master bus
);

  localparam int AW_A = addr_w(M1 * N1);
  localparam int AW_B = addr_w(N1 * N2);
  localparam int AW_R = addr_w(M1 * N2);
  localparam int IW   = addr_w(M1);
  localparam int JW   = addr_w(N2);
  localparam int KW   = addr_w(N1);

  // The accumulator must hold N1 full-width products without wrapping.
  if (ACC_W < 2 * DATA_W + $clog2(N1) + 1) begin : g_acc_w_check
    $error("matmul_sequencer: ACC_W too narrow for DATA_W/N1");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic [IW-1:0] r_i, w_i_nxt;
  logic [JW-1:0] r_j, w_j_nxt;
  logic [KW-1:0] r_k, w_k_nxt;

  logic w_rd_en;
  logic w_last_i;
  logic w_last_j;
  logic w_last_k;

  // Read strobe and first-of-element flag, delayed to line up with RAM data.
  logic r_rd_vld;
  logic r_rd_first;

  logic signed [ACC_W-1:0]  w_acc;
  logic signed [DATA_W-1:0] w_sat;
  logic signed [DATA_W-1:0] r_data_q;

  assign w_last_i = (r_i == IW'(M1 - 1));
  assign w_last_j = (r_j == JW'(N2 - 1));
  assign w_last_k = (r_k == KW'(N1 - 1));
  assign w_rd_en  = (r_state == FETCH);

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = FETCH;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_k_nxt     = '0;
        end
      end
      FETCH: begin
        if (w_last_k) begin
          w_state_nxt = DRAIN;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      DRAIN: begin
        // Final product of the element lands in the MAC this cycle.
        w_state_nxt = WRITE;
      end
      WRITE: begin
        w_k_nxt     = '0;
        w_state_nxt = FETCH;
        if (w_last_j) begin
          w_j_nxt = '0;
          if (w_last_i) begin
            w_i_nxt     = '0;
            w_state_nxt = DONE;
          end else begin
            w_i_nxt = r_i + IW'(1);
          end
        end else begin
          w_j_nxt = r_j + JW'(1);
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_first <= 1'b0;
      r_data_q   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_k        <= w_k_nxt;
      r_rd_vld   <= w_rd_en;
      r_rd_first <= w_rd_en && (r_k == '0);
      if (r_state == WRITE) begin
        r_data_q <= w_sat;
      end
    end
  end

  fixed_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_a     (bus.a_data),
    .i_b     (bus.b_data),
    .i_vld   (r_rd_vld),
    .i_first (r_rd_first),
    .o_acc   (w_acc)
  );

  assign w_sat = DATA_W'(sat_shift(128'(w_acc), FRAC, DATA_W));

  assign bus.busy    = (r_state == FETCH) || (r_state == DRAIN) || (r_state == WRITE);
  assign bus.done    = (r_state == DONE);
  assign bus.a_rd_en = w_rd_en;
  assign bus.b_rd_en = w_rd_en;
  assign bus.a_addr  = AW_A'(r_i) * AW_A'(N1) + AW_A'(r_k);
  assign bus.b_addr  = AW_B'(r_k) * AW_B'(N2) + AW_B'(r_j);
  assign bus.r_we    = (r_state == WRITE);
  assign bus.r_addr  = AW_R'(r_i) * AW_R'(N2) + AW_R'(r_j);
  // Present the fresh result during WRITE, otherwise hold the last one.
  assign bus.r_data  = (r_state == WRITE) ? w_sat : r_data_q;

endmodule
